// File: rtl/led_pwm_pkg.sv
// Board-level constants shared by the LED output blocks, plus a helper that
// sizes the PWM prescaler from the on-chip oscillator frequency.
package led_pwm_pkg;

  localparam int LED_COUNT      = 32'sd8;
  localparam int DUTY_WIDTH     = 32'sd8;
  localparam int LED_ACTIVE_LOW = 32'sd1;
  localparam int OSC_HZ         = 32'sd133_000_000;

  // Clocks per PWM tick for a target period rate; never below one clock.
  function automatic int prescale_for(input int pwm_hz, input int width);
    int ticks_per_s;
    int p;
    ticks_per_s = pwm_hz <<< width;
    p = (ticks_per_s > 32'sd0) ? (OSC_HZ / ticks_per_s) : 32'sd1;
    if (p < 32'sd1) p = 32'sd1;
    return p;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus free-running period counter; shared by LED PWM and any
// future blink/breathe generators that must stay phase-aligned.
module pwm_timebase #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 16
) (
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap,
  output logic             period_start
);

  localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_LAST   = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] COUNT_LAST = {WIDTH{1'b1}};

  logic [PW-1:0]    prescaler_r;
  logic [WIDTH-1:0] count_r;
  logic             period_start_r;

  assign tick         = (prescaler_r == PRE_LAST);
  assign wrap         = tick && (count_r == COUNT_LAST);
  assign count        = count_r;
  assign period_start = period_start_r;

  // Prescaler: with PRESCALE=1 it stays at zero and every clock is a tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler_r <= {PW{1'b0}};
    end else if (tick) begin
      prescaler_r <= {PW{1'b0}};
    end else begin
      prescaler_r <= prescaler_r + PW'(1);
    end
  end

  // Period counter wraps naturally from all-ones to zero on a tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (tick) begin
      count_r <= count_r + WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Marks the first clock of count==0 after a wrap, so never out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      period_start_r <= 1'b0;
    end else begin
      period_start_r <= wrap;
    end
  end

endmodule

// File: rtl/led_pwm.sv
// Multi-channel LED PWM driver: brightness words arrive over valid/ready and
// are swapped in only at a period boundary so no period mixes duty values.
module led_pwm
  import led_pwm_pkg::*;
#(
  parameter int CHANNELS = LED_COUNT,
  parameter int WIDTH    = DUTY_WIDTH,
  parameter int PRESCALE = 16,
  parameter int INVERT   = LED_ACTIVE_LOW
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic                      load,
  output logic                      ready,
  output logic [CHANNELS-1:0]       leds,
  output logic                      period_start
);

  localparam logic INV_BIT = (INVERT != 0);

  logic [WIDTH-1:0]          count_s;
  logic                      tick_s;
  logic                      wrap_s;
  logic                      accept_s;
  logic                      apply_s;
  logic [CHANNELS-1:0]       on_s;
  logic [CHANNELS*WIDTH-1:0] shadow_r;
  logic [CHANNELS*WIDTH-1:0] active_r;
  logic                      pending_r;
  logic                      ready_r;
  logic [CHANNELS-1:0]       leds_r;

  pwm_timebase #(
    .WIDTH    (WIDTH),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clock        (clock),
    .reset        (reset),
    .count        (count_s),
    .tick         (tick_s),
    .wrap         (wrap_s),
    .period_start (period_start)
  );

  // ready is always the complement of pending, so accept and apply never coincide.
  assign accept_s = load && ready_r;
  assign apply_s  = tick_s && wrap_s && pending_r;
  assign ready    = ready_r;
  assign leds     = leds_r;

  // Shadow/active duty registers and the handshake state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_r  <= {(CHANNELS*WIDTH){1'b0}};
      active_r  <= {(CHANNELS*WIDTH){1'b0}};
      pending_r <= 1'b0;
      ready_r   <= 1'b1;
    end else if (accept_s) begin
      shadow_r  <= duty;
      pending_r <= 1'b1;
      ready_r   <= 1'b0;
    end else if (apply_s) begin
      active_r  <= shadow_r;
      pending_r <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      pending_r <= pending_r;
      ready_r   <= ready_r;
    end
  end

  // Per-channel comparators against the shared counter.
  always_comb begin
    on_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      on_s[i] = (count_s < active_r[i*WIDTH +: WIDTH]);
    end
  end

  // Registered pin drive with board polarity applied.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      leds_r <= {CHANNELS{INV_BIT}};
    end else begin
      leds_r <= on_s ^ {CHANNELS{INV_BIT}};
    end
  end

endmodule

// File: tb/tb_led_pwm.sv
// Randomised self-checking bench for led_pwm against a cycle-indexed reference
// model; a second instance covers non-inverted pins with PRESCALE=1.
module tb_led_pwm;

  localparam int CH  = 2;
  localparam int W   = 4;
  localparam int PRE = 2;
  localparam int INV = 1;
  localparam int PER = PRE * (1 << W);

  logic       clock = 1'b0;
  logic       reset, load, ready, period_start;
  logic [7:0] duty;
  logic [1:0] leds;
  logic       reset_b, load_b, ready_b, period_start_b;
  logic [7:0] duty_b;
  logic [1:0] leds_b;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: k counts clocks since reset release.
  int         k;
  logic [7:0] m_act, m_shadow;
  bit         m_pend;
  logic [1:0] m_leds;

  always #5 clock = ~clock;

  led_pwm #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(PRE), .INVERT(INV)) dut (
    .clock(clock), .reset(reset), .duty(duty), .load(load),
    .ready(ready), .leds(leds), .period_start(period_start)
  );

  led_pwm #(.CHANNELS(2), .WIDTH(4), .PRESCALE(1), .INVERT(0)) dut_b (
    .clock(clock), .reset(reset_b), .duty(duty_b), .load(load_b),
    .ready(ready_b), .leds(leds_b), .period_start(period_start_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (k=%0d): got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  function automatic int cnt_at(input int t);
    return (t / PRE) % (1 << W);
  endfunction

  task automatic model_reset();
    k        = 0;
    m_act    = 8'h00;
    m_shadow = 8'h00;
    m_pend   = 1'b0;
    m_leds   = (INV != 0) ? 2'b11 : 2'b00;
  endtask

  // Check the current clock's outputs, drive this clock's inputs, advance the model.
  task automatic step(input bit ld, input logic [7:0] d);
    bit acc;
    check_eq("leds", {30'd0, leds}, {30'd0, m_leds});
    check_eq("ready", {31'd0, ready}, {31'd0, !m_pend});
    check_eq("period_start", {31'd0, period_start}, {31'd0, (k > 0) && (k % PER == 0)});
    load = ld;
    duty = d;
    for (int c = 0; c < CH; c++)
      m_leds[c] = (INV != 0) ^ (cnt_at(k) < int'(m_act[c*W +: W]));
    acc = ld && !m_pend;
    if ((k % PER == PER - 1) && m_pend) begin
      m_act  = m_shadow;
      m_pend = 1'b0;
    end
    if (acc) begin
      m_shadow = d;
      m_pend   = 1'b1;
    end
    k++;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; duty = 8'h00;
    reset_b = 1'b1; load_b = 1'b0; duty_b = 8'h00;
    k = 0;
    repeat (3) @(negedge clock);
    check_eq("rst_leds", {30'd0, leds}, 32'h3);
    check_eq("rst_ready", {31'd0, ready}, 32'h1);
    check_eq("rst_period_start", {31'd0, period_start}, 32'h0);

    reset = 1'b0;
    model_reset();
    // Directed: early load, load on a wrap cycle, and a load while busy.
    for (int i = 0; i < 160; i++) begin
      case (i)
        3:       step(1'b1, 8'h08);
        63:      step(1'b1, 8'hF1);
        100:     step(1'b1, 8'h33);
        105:     step(1'b1, 8'h55);
        default: step(1'b0, 8'h00);
      endcase
    end

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) == 0, 8'($urandom));

    // Mid-period reset with a value still pending in the shadow.
    while (m_pend) step(1'b0, 8'h00);
    step(1'b1, 8'($urandom) | 8'h11);
    repeat (5) step(1'b0, 8'h00);
    reset = 1'b1;
    #1;
    check_eq("async_rst_leds", {30'd0, leds}, 32'h3);
    check_eq("async_rst_ready", {31'd0, ready}, 32'h1);
    check_eq("async_rst_period_start", {31'd0, period_start}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    repeat (70) step(1'b0, 8'h00);
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 2) == 0, 8'($urandom));
    load = 1'b0;

    // Non-inverted, PRESCALE=1: both channels at duty 5, loaded on clock 2.
    reset_b = 1'b0;
    for (int j = 0; j < 81; j++) begin
      k = j;
      check_eq("b_leds", {30'd0, leds_b},
               ((j >= 17) && (((j - 1) % 16) < 5)) ? 32'h3 : 32'h0);
      check_eq("b_period_start", {31'd0, period_start_b}, {31'd0, (j > 0) && (j % 16 == 0)});
      check_eq("b_ready", {31'd0, ready_b}, {31'd0, !((j >= 3) && (j <= 15))});
      load_b = (j == 2);
      duty_b = 8'h55;
      @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
